// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the two-requester data-memory arbiter.
// Imported by the arbiter top and its round-robin picker.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    localparam logic [31:0] RESP_ZERO = 32'h0;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester
// that did not win last time is chosen.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant_id = REQ_CORE;
        unique case (1'b1)
            (valid == 2'b11): grant_id = ~last;
            (valid == 2'b10): grant_id = REQ_DBG;
            default:          grant_id = REQ_CORE;
        endcase
        grant = {grant_id, ~grant_id} & {2{|valid}};
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous data memory between the
// core data port and the debug/loader master, one access at a time.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_valid_i,
    output logic              m0_ready_o,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [31:0]       m0_wdata_i,
    output logic              m0_resp_o,
    output logic              m0_err_o,
    output logic [31:0]       m0_rdata_o,

    input  logic              m1_valid_i,
    output logic              m1_ready_o,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [31:0]       m1_wdata_i,
    output logic              m1_resp_o,
    output logic              m1_err_o,
    output logic [31:0]       m1_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,

    output logic              busy_o
);

    localparam logic [ADDR_W-1:0] WORD_LIMIT =
        ADDR_W'(MEM_WORDS);

    arb_state_e state_q;
    arb_state_e state_d;

    logic              last_q;
    logic              owner_q;
    logic              we_q;
    logic              err_q;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic [1:0]        grant;
    logic              grant_id;
    logic [1:0]        ready;
    logic              accept;
    logic              resp;
    logic [31:0]       resp_data;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_ok;

    rr_pick2 u_pick (
        .valid    ({m1_valid_i, m0_valid_i}),
        .last     (last_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign sel_we    = grant_id ? m1_we_i    : m0_we_i;
    assign sel_addr  = grant_id ? m1_addr_i  : m0_addr_i;
    assign sel_wdata = grant_id ? m1_wdata_i : m0_wdata_i;

    // Compare the full word index so high bits never alias into range.
    assign sel_ok =
        (sel_addr[1:0] == 2'b00) &&
        ({2'b00, sel_addr[ADDR_W-1:2]} < WORD_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 2'b00;
        resp    = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = grant & {2{~rst_i}};
                if (|ready) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                resp    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept = |ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q      <= REQ_DBG;
            owner_q     <= REQ_CORE;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= RESP_ZERO;
        end else if (accept) begin
            last_q      <= grant_id;
            owner_q     <= grant_id;
            we_q        <= sel_we;
            err_q       <= ~sel_ok;
            mem_en_q    <= sel_ok;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
        end else if (state_q == ISSUE) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= RESP_ZERO;
        end
    end

    // Read data only passes through for a legal read.
    assign resp_data =
        (resp && !err_q && !we_q) ? mem_rdata_i : RESP_ZERO;

    assign m0_ready_o = ready[0];
    assign m1_ready_o = ready[1];

    assign m0_resp_o  = resp & (owner_q == REQ_CORE);
    assign m1_resp_o  = resp & (owner_q == REQ_DBG);
    assign m0_err_o   = m0_resp_o & err_q;
    assign m1_err_o   = m1_resp_o & err_q;
    assign m0_rdata_o = m0_resp_o ? resp_data : RESP_ZERO;
    assign m1_rdata_o = m1_resp_o ? resp_data : RESP_ZERO;

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    assign busy_o = (state_q != IDLE);

endmodule
